exchange_writer: RTL

//  Downstream stage of the free-list controller. Consumes one exchange (src,dest) per valid/write_fin handshake.

---
 rtl/redundancy_pkg.sv | 18 +
 rtl/exchange_writer_if.sv | 28 ++
 rtl/exw_rd_tag_pipe.sv | 38 +++
 rtl/exchange_writer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/redundancy_pkg.sv
// Shared types and default widths for the free-list controller and the exchange writer.
// EXW_SWAP_EN adds the RD_DEST and WR_SRC states used by the true-swap build.
package redundancy_pkg;

    localparam int EXW_WORD_WIDTH = 8;
    localparam int EXW_ITER_WIDTH = 9;

`ifdef EXW_SWAP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RD_SRC, S_RD_DEST, S_WAIT, S_WR_DEST, S_WR_SRC, S_FIN
    } exw_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_RD_SRC, S_WAIT, S_WR_DEST, S_FIN
    } exw_state_t;
`endif

endpackage

// File: rtl/exchange_writer_if.sv
// Exchange request channel (controller -> writer) and single-read/single-write memory port.
// The writer uses xchg.slave and mem.master.
interface exw_xchg_if #(
    parameter int ITER_WIDTH = redundancy_pkg::EXW_ITER_WIDTH
);
    logic                  valid;
    logic [ITER_WIDTH-1:0] e_src_it;
    logic [ITER_WIDTH-1:0] e_dest_it;
    logic                  write_fin;

    modport master (output valid, e_src_it, e_dest_it, input write_fin);
    modport slave  (input valid, e_src_it, e_dest_it, output write_fin);
endinterface

interface exw_mem_if #(
    parameter int WORD_WIDTH = redundancy_pkg::EXW_WORD_WIDTH,
    parameter int ITER_WIDTH = redundancy_pkg::EXW_ITER_WIDTH
);
    logic                  rd_en;
    logic [ITER_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ITER_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;

    modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/exw_rd_tag_pipe.sv
// Follows each memory read for RD_LATENCY cycles and raises the capture strobe for its data register.
// Synchronous flush drops every tag in flight so late read data is never captured.
module exw_rd_tag_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic push,
    input  logic push_dest,
    output logic cap_src,
    output logic cap_dest
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] dst_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            dst_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
            dst_q <= '0;
        end else begin
            vld_q[0] <= push;
            dst_q[0] <= push_dest;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dst_q[i] <= dst_q[i-1];
            end
        end
    end

    assign cap_src  = vld_q[RD_LATENCY-1] & ~dst_q[RD_LATENCY-1];
    assign cap_dest = vld_q[RD_LATENCY-1] &  dst_q[RD_LATENCY-1];

endmodule

// File: rtl/exchange_writer.sv
// Copies mem[src] to mem[dest] per accepted exchange; EXW_SWAP_EN makes it a true swap.
// write_fin comes 3+RD_LATENCY cycles after accept (5+RD_LATENCY when swapping); set_idle aborts.
module exchange_writer
    import redundancy_pkg::*;
#(
    parameter int WORD_WIDTH = EXW_WORD_WIDTH,
    parameter int ITER_WIDTH = EXW_ITER_WIDTH,
    parameter int MEM_DEPTH  = 512,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_idle,
    input  logic                 enable_in,
    exw_xchg_if.slave            xchg,
    exw_mem_if.master            mem,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] xchg_count,
    output logic                 err_range
);

    localparam logic [ITER_WIDTH:0] DEPTH = (ITER_WIDTH+1)'(MEM_DEPTH);

    exw_state_t            state, state_n;
    logic [ITER_WIDTH-1:0] src_q, dest_q, src_n;
    logic [WORD_WIDTH-1:0] src_word, src_word_n;
    logic                  cnt_ok;
    logic                  accept, in_range, cap_src, cap_dest, last_cap, push_dest;
    logic                  rd_en_d, wr_en_d, fin_d;
    logic [ITER_WIDTH-1:0] rd_addr_d, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_d;
    logic                  rd_en_q, wr_en_q, fin_q;
    logic [ITER_WIDTH-1:0] rd_addr_q, wr_addr_q;
    logic [WORD_WIDTH-1:0] wr_data_q;
`ifdef EXW_SWAP_EN
    logic [WORD_WIDTH-1:0] dest_word, dest_word_n;
    assign dest_word_n = cap_dest ? mem.rd_data : dest_word;
    assign push_dest   = (state == S_RD_DEST);
    assign last_cap    = cap_dest;
`else
    assign push_dest   = 1'b0;
    // No dest tag is ever pushed in the copy build, so this is the src capture.
    assign last_cap    = cap_src | cap_dest;
`endif

    assign in_range   = ({1'b0, xchg.e_src_it} < DEPTH) && ({1'b0, xchg.e_dest_it} < DEPTH);
    assign accept     = (state == S_IDLE) && xchg.valid && enable_in && !set_idle;
    assign src_n      = accept ? xchg.e_src_it : src_q;
    assign src_word_n = cap_src ? mem.rd_data : src_word;
    assign busy       = (state != S_IDLE);

    exw_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (set_idle),
        .push      (rd_en_q),
        .push_dest (push_dest),
        .cap_src   (cap_src),
        .cap_dest  (cap_dest)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (set_idle) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (!in_range || xchg.e_src_it == xchg.e_dest_it) state_n = S_FIN;
                    else                                              state_n = S_RD_SRC;
                end
`ifdef EXW_SWAP_EN
                S_RD_SRC:  state_n = S_RD_DEST;
                S_RD_DEST: state_n = S_WAIT;
                S_WR_DEST: state_n = S_WR_SRC;
                S_WR_SRC:  state_n = S_FIN;
`else
                S_RD_SRC:  state_n = S_WAIT;
                S_WR_DEST: state_n = S_FIN;
`endif
                S_WAIT:    if (last_cap) state_n = S_WR_DEST;
                S_FIN:     state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    // Decoded from the next state so every memory-facing output leaves a flop.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        fin_d     = 1'b0;
        case (state_n)
            S_RD_SRC:  begin rd_en_d = 1'b1; rd_addr_d = src_n; end
            S_WR_DEST: begin wr_en_d = 1'b1; wr_addr_d = dest_q; wr_data_d = src_word_n; end
`ifdef EXW_SWAP_EN
            S_RD_DEST: begin rd_en_d = 1'b1; rd_addr_d = dest_q; end
            S_WR_SRC:  begin wr_en_d = 1'b1; wr_addr_d = src_q; wr_data_d = dest_word_n; end
`endif
            S_FIN:     fin_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            fin_q      <= 1'b0;
            src_q      <= '0;
            dest_q     <= '0;
            src_word   <= '0;
            cnt_ok     <= 1'b0;
            xchg_count <= '0;
            err_range  <= 1'b0;
`ifdef EXW_SWAP_EN
            dest_word  <= '0;
`endif
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fin_q     <= fin_d;
            src_word  <= src_word_n;
`ifdef EXW_SWAP_EN
            dest_word <= dest_word_n;
`endif
            if (accept) begin
                src_q  <= xchg.e_src_it;
                dest_q <= xchg.e_dest_it;
                cnt_ok <= in_range;
                if (!in_range) err_range <= 1'b1;
            end
            if (state == S_FIN && cnt_ok && xchg_count != {CNT_WIDTH{1'b1}})
                xchg_count <= xchg_count + 1'b1;
        end
    end

    assign mem.rd_en      = rd_en_q;
    assign mem.rd_addr    = rd_addr_q;
    assign mem.wr_en      = wr_en_q;
    assign mem.wr_addr    = wr_addr_q;
    assign mem.wr_data    = wr_data_q;
    assign xchg.write_fin = fin_q;

endmodule
